// File: rtl/voq_rr_scheduler_pkg.sv
// Switch-wide scheduler constants and the matcher FSM state encoding.
package voq_rr_scheduler_pkg;

  localparam int PORTS  = 4;
  localparam int PORT_W = $clog2(PORTS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PICK = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/voq_rr_scheduler_rr_pick.sv
// Combinational round-robin finder: first egress at or after start_idx that is
// neither empty nor already picked. Rotate, priority-find, then unrotate.
module rr_pick #(
  parameter int PORTS  = 4,
  parameter int PORT_W = $clog2(PORTS)
) (
  input  logic [PORT_W-1:0] start_idx,
  input  logic [PORTS-1:0]  empty,
  input  logic [PORTS-1:0]  picked,
  output logic [PORT_W-1:0] pick_idx,
  output logic              none
);

  logic [PORTS-1:0]  avail_rot_s;
  logic [PORT_W-1:0] offset_s;
  logic              found_s;

  // Rotate availability so bit 0 is start_idx, take the lowest set bit, map back.
  always_comb begin
    avail_rot_s = '0;
    offset_s    = '0;
    found_s     = 1'b0;
    for (int j = 0; j < PORTS; j++) begin
      avail_rot_s[j] = ~empty[start_idx + PORT_W'(j)] & ~picked[start_idx + PORT_W'(j)];
    end
    for (int j = 0; j < PORTS; j++) begin
      if (avail_rot_s[j] && !found_s) begin
        found_s  = 1'b1;
        offset_s = PORT_W'(j);
      end else begin
        found_s  = found_s;
      end
    end
    pick_idx = start_idx + offset_s;
    none     = ~found_s;
  end

endmodule

// File: rtl/voq_rr_scheduler.sv
// PORTS x PORTS VOQ matcher: visits one ingress per cycle in rotating order and
// grants each the next free egress after its own persistent round-robin pointer.
module voq_rr_scheduler
  import voq_rr_scheduler_pkg::*;
#(
  parameter int PORTS  = voq_rr_scheduler_pkg::PORTS,
  parameter int PORT_W = $clog2(PORTS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [PORTS*PORTS-1:0]    voq_empty,
  output logic                      busy,
  output logic                      done,
  output logic [PORTS-1:0]          match_valid,
  output logic [PORTS*PORT_W-1:0]   match_egress
);

  state_e                    state_r;
  logic [PORT_W-1:0]         k_r;
  logic [PORT_W-1:0]         first_ing_r;
  logic [PORT_W-1:0]         ptr_r [PORTS];
  logic [PORTS*PORTS-1:0]    empty_q_r;
  logic [PORTS-1:0]          picked_r;
  logic [PORTS-1:0]          match_valid_r;
  logic [PORTS*PORT_W-1:0]   match_egress_r;
  logic                      busy_r;
  logic                      done_r;

  logic [PORT_W-1:0]         idx_s;
  logic [PORT_W-1:0]         cur_ptr_s;
  logic [PORTS-1:0]          cur_empty_s;
  logic [PORT_W-1:0]         pick_s;
  logic                      none_s;

  // Select the ingress being visited this cycle and its pointer / VOQ snapshot.
  always_comb begin
    idx_s       = first_ing_r + k_r;
    cur_ptr_s   = ptr_r[idx_s];
    cur_empty_s = empty_q_r[idx_s*PORTS +: PORTS];
  end

  rr_pick #(
    .PORTS  (PORTS),
    .PORT_W (PORT_W)
  ) u_rr_pick (
    .start_idx (cur_ptr_s),
    .empty     (cur_empty_s),
    .picked    (picked_r),
    .pick_idx  (pick_s),
    .none      (none_s)
  );

  // Epoch FSM, pointer updates and match registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r        <= S_IDLE;
      k_r            <= '0;
      first_ing_r    <= '0;
      empty_q_r      <= '0;
      picked_r       <= '0;
      match_valid_r  <= '0;
      match_egress_r <= '0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      for (int i = 0; i < PORTS; i++) begin
        ptr_r[i] <= '0;
      end
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            empty_q_r      <= voq_empty;
            picked_r       <= '0;
            match_valid_r  <= '0;
            match_egress_r <= '0;
            k_r            <= '0;
            busy_r         <= 1'b1;
            state_r        <= S_PICK;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_PICK: begin
          if (!none_s) begin
            match_valid_r[idx_s]                     <= 1'b1;
            match_egress_r[idx_s*PORT_W +: PORT_W]   <= pick_s;
            picked_r[pick_s]                         <= 1'b1;
            ptr_r[idx_s]                             <= pick_s + PORT_W'(1);
          end else begin
            match_valid_r[idx_s]                     <= 1'b0;
            match_egress_r[idx_s*PORT_W +: PORT_W]   <= '0;
          end
          k_r <= k_r + PORT_W'(1);
          // Fixed latency: every ingress is visited even once all egresses are taken.
          if (k_r == PORT_W'(PORTS-1)) begin
            done_r  <= 1'b1;
            state_r <= S_DONE;
          end else begin
            state_r <= S_PICK;
          end
        end
        S_DONE: begin
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
          first_ing_r <= first_ing_r + PORT_W'(1);
          state_r     <= S_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign match_valid  = match_valid_r;
  assign match_egress = match_egress_r;

endmodule
